mem_strobe_controller: RTL and testbench

- Initiator-side sequencer that turns single-cycle load/store requests from the pipeline MEM stage into timed memory strobes: chip_select, out_enable, wire_enable, plus address and data.
- Sits between the MEM stage and the data-memory array.
- The memory side turns these strobes into its read/write modes. This block guarantees setup/strobe/hold timing and that read and write strobes are mutually exclusive.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_phase_counter.sv | 45 ++++
 rtl/mem_strobe_controller.sv | 188 ++++++++++++++++++
 tb/tb_mem_strobe_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and constants for the data-memory strobe controller:
//   FSM state encoding, default phase timing and access-type codes.
//   Also provides max3(), used to size the phase counter.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_e;

   localparam int unsigned DEF_SETUP_CYCLES  = 1;
   localparam int unsigned DEF_STROBE_CYCLES = 2;
   localparam int unsigned DEF_HOLD_CYCLES   = 1;

   localparam logic ACC_READ  = 1'b0;
   localparam logic ACC_WRITE = 1'b1;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/mem_phase_counter.sv
// mem_phase_counter
//   Loadable down-counter shared by all access phases. It saturates at
//   zero, and it holds its value when neither load nor dec is asserted.
// Ports:
//   clk, rst_n          clock / synchronous active-low reset
//   load, load_val      reload the counter (takes priority over dec)
//   dec                 count down by one
//   tc                  current count is zero (terminal count)
//   tc_next             count after this edge will be zero
module mem_phase_counter #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             tc,
   output logic             tc_next
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc      = (count_q == '0);
   assign tc_next = (count_d == '0);

endmodule

// File: rtl/mem_strobe_controller.sv
// mem_strobe_controller
//   Turns single-cycle load/store requests from the MEM stage into timed
//   memory strobes: SETUP (chip_select + address), STROBE (out_enable for
//   reads, wire_enable for writes), then HOLD (chip_select + address).
//   All outputs are registered. They are computed from the next state, so
//   each output changes on the same edge as the state transition.
//   Optional macro MEM_WAIT_STATE_EN adds input mem_wait. While mem_wait
//   is high in the final STROBE cycle, that cycle repeats.
// Ports:
//   clk, rst_n                       clock / synchronous active-low reset
//   req, req_we, req_addr, req_wdata request from MEM stage (taken when ready)
//   ready                            controller idle
//   done                             one-cycle pulse in the last HOLD cycle
//   rdata                            last captured read data
//   mem_addr, mem_wdata, mem_rdata   memory address / data buses
//   mem_wait                         (MEM_WAIT_STATE_EN only) extend STROBE
//   chip_select, out_enable, wire_enable  memory strobes
module mem_strobe_controller
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  ready,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_WAIT_STATE_EN
   input  logic                  mem_wait,
`endif
   output logic                  chip_select,
   output logic                  out_enable,
   output logic                  wire_enable
);

   localparam int unsigned CNT_W = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

   state_e                state_q, state_d;
   logic                  acc_we_q, acc_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic                  cs_q, cs_d;
   logic                  oe_q, oe_d;
   logic                  we_q, we_d;

   logic                  cnt_load;
   logic [CNT_W-1:0]      cnt_load_val;
   logic                  cnt_dec;
   logic                  cnt_tc;
   logic                  cnt_tc_next;
   logic                  strobe_release;

`ifdef MEM_WAIT_STATE_EN
   assign strobe_release = ~mem_wait;
`else
   assign strobe_release = 1'b1;
`endif

   mem_phase_counter #(
      .WIDTH (CNT_W)
   ) u_phase_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .tc       (cnt_tc),
      .tc_next  (cnt_tc_next)
   );

   always_comb begin
      state_d      = state_q;
      acc_we_d     = acc_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rdata_d      = rdata_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d      = SETUP;
               acc_we_d     = req_we;
               mem_addr_d   = req_addr;
               mem_wdata_d  = req_wdata;
               cnt_load     = 1'b1;
               cnt_load_val = SETUP_LOAD;
            end
         end
         SETUP: begin
            if (cnt_tc) begin
               state_d      = STROBE;
               cnt_load     = 1'b1;
               cnt_load_val = STROBE_LOAD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         STROBE: begin
            // A wait request in the last strobe cycle repeats that cycle.
            // The counter stays at zero until the memory releases it.
            if (cnt_tc) begin
               if (strobe_release) begin
                  state_d      = HOLD;
                  cnt_load     = 1'b1;
                  cnt_load_val = HOLD_LOAD;
                  if (acc_we_q == ACC_READ) begin
                     rdata_d = mem_rdata;
                  end
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         HOLD: begin
            if (cnt_tc) begin
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from the next state so that they register in step with it.
      ready_d = (state_d == IDLE);
      cs_d    = (state_d != IDLE);
      oe_d    = (state_d == STROBE) && (acc_we_d == ACC_READ);
      we_d    = (state_d == STROBE) && (acc_we_d == ACC_WRITE);
      done_d  = (state_d == HOLD) && cnt_tc_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_we_q    <= ACC_READ;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         cs_q        <= 1'b0;
         oe_q        <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_we_q    <= acc_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         cs_q        <= cs_d;
         oe_q        <= oe_d;
         we_q        <= we_d;
      end
   end

   assign ready       = ready_q;
   assign done        = done_q;
   assign rdata       = rdata_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign chip_select = cs_q;
   assign out_enable  = oe_q;
   assign wire_enable = we_q;

endmodule

// File: tb/tb_mem_strobe_controller.sv
// tb_mem_strobe_controller
//   Directed bench for mem_strobe_controller with default timing
//   (SETUP=1, STROBE=2, HOLD=1). Stimulus pushes expected completions into
//   a scoreboard. A negedge monitor pops one entry on each done pulse and
//   checks the completion cycle, address, write data and read data.
//   Define MEM_WAIT_STATE_EN to include the wait-state access.
module tb_mem_strobe_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef MEM_WAIT_STATE_EN
   logic        mem_wait;
`endif
   logic        chip_select;
   logic        out_enable;
   logic        wire_enable;

   int total = 0;
   int bad   = 0;
   int edge_cnt = 0;
   logic [31:0] last_rd = '0;

   typedef struct {
      int          done_edge;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;
   exp_t sbq[$];

   mem_strobe_controller #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .SETUP_CYCLES  (1),
      .STROBE_CYCLES (2),
      .HOLD_CYCLES   (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .ready       (ready),
      .done        (done),
      .rdata       (rdata),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
`ifdef MEM_WAIT_STATE_EN
      .mem_wait    (mem_wait),
`endif
      .chip_select (chip_select),
      .out_enable  (out_enable),
      .wire_enable (wire_enable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: strobe invariants every cycle, scoreboard pop on each done.
   always @(negedge clk) begin
      exp_t e;
      chk("oe_we_exclusive", {63'd0, out_enable & wire_enable}, 64'd0);
      chk("strobe_without_cs", {63'd0, (out_enable | wire_enable) & ~chip_select}, 64'd0);
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sbq.pop_front();
            chk("done_cycle", 64'(edge_cnt), 64'(e.done_edge));
            chk("done_addr", {32'd0, mem_addr}, {32'd0, e.addr});
            if (e.we) chk("done_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
            chk("done_rdata", {32'd0, rdata}, {32'd0, e.rdata});
         end
      end
   end

   // One access issued at a negedge while idle. The strobe profile is
   // checked cycle by cycle. mem_rdata carries the real data only in the
   // final strobe cycle.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdat, input int nwait);
      exp_t e;
      logic exp_cs, exp_oe, exp_we, exp_rdy;
      chk("issue_ready", {63'd0, ready}, 64'd1);
      req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; mem_rdata = ~rdat;
      e.done_edge = edge_cnt + 4 + nwait;
      e.we = we; e.addr = addr; e.wdata = wdata;
      if (!we) last_rd = rdat;
      e.rdata = last_rd;
      sbq.push_back(e);
      for (int k = 1; k <= 5 + nwait; k++) begin
         @(negedge clk);
         req = 1'b0; req_addr = ~addr; req_wdata = ~wdata;
         mem_rdata = (k == 3 + nwait) ? rdat : ~rdat;
`ifdef MEM_WAIT_STATE_EN
         mem_wait = (k >= 3) && (k < 3 + nwait);
`endif
         exp_cs  = (k <= 4 + nwait);
         exp_oe  = !we && (k >= 2) && (k <= 3 + nwait);
         exp_we  = we && (k >= 2) && (k <= 3 + nwait);
         exp_rdy = (k == 5 + nwait);
         chk("chip_select", {63'd0, chip_select}, {63'd0, exp_cs});
         chk("out_enable", {63'd0, out_enable}, {63'd0, exp_oe});
         chk("wire_enable", {63'd0, wire_enable}, {63'd0, exp_we});
         chk("ready", {63'd0, ready}, {63'd0, exp_rdy});
         chk("mem_addr", {32'd0, mem_addr}, {32'd0, addr});
         if (we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, wdata});
      end
      chk("rdata_after", {32'd0, rdata}, {32'd0, last_rd});
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_rdata = 32'h0BAD_F00D;
`ifdef MEM_WAIT_STATE_EN
      mem_wait = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_strobes", {61'd0, chip_select, out_enable, wire_enable}, 64'd0);
      chk("rst_rdata", {32'd0, rdata}, 64'd0);
      chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", {63'd0, ready}, 64'd1);
         chk("idle_done", {63'd0, done}, 64'd0);
      end

      access(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
      access(1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0, 0);

      // Back-to-back, req held: write accepted at T, read at T+5. The
      // request fields change while busy and must not reach mem_addr.
      req = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'hA5A5_A5A5;
      mem_rdata = 32'h55AA_55AA;
      e.done_edge = edge_cnt + 4; e.we = 1'b1; e.addr = 32'h100; e.wdata = 32'hA5A5_A5A5;
      e.rdata = last_rd;
      sbq.push_back(e);
      e.done_edge = edge_cnt + 9; e.we = 1'b0; e.addr = 32'h104; e.wdata = 32'h0;
      e.rdata = 32'h55AA_55AA;
      sbq.push_back(e);
      last_rd = 32'h55AA_55AA;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 2) begin req_we = 1'b0; req_addr = 32'h104; req_wdata = 32'h0; end
         if (k == 6) req = 1'b0;
         chk("b2b_ready", {63'd0, ready}, {63'd0, (k == 5) || (k == 10)});
         chk("b2b_mem_addr", {32'd0, mem_addr}, (k <= 5) ? 64'h100 : 64'h104);
      end

      // Reset in the first strobe cycle abandons the access.
      req = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_wdata = 32'h0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("mid_oe_before_rst", {63'd0, out_enable}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_strobes", {61'd0, chip_select, out_enable, wire_enable}, 64'd0);
      chk("mid_ready", {63'd0, ready}, 64'd1);
      chk("mid_rdata", {32'd0, rdata}, 64'd0);
      chk("mid_mem_addr", {32'd0, mem_addr}, 64'd0);
      last_rd = '0;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid_ready_after", {63'd0, ready}, 64'd1);

      access(1'b0, 32'h0000_0044, 32'h0, 32'h0F0F_1234, 0);
`ifdef MEM_WAIT_STATE_EN
      access(1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 3);
      access(1'b1, 32'h0000_0204, 32'h7777_1111, 32'h0, 1);
`endif

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
